// File: rtl/imm_encoder_pkg.sv
// Shared definitions for the instruction immediate encoder: formats, data types
// and the request bundle handed from the pipeline front to the field packer.
package imm_encoder_pkg;

  localparam int XLEN = 32;

  typedef logic [XLEN-1:0] data_t;

  typedef enum logic [2:0] {
    IMM_I_TYPE = 3'd0,
    IMM_S_TYPE = 3'd1,
    IMM_B_TYPE = 3'd2,
    IMM_U_TYPE = 3'd3,
    IMM_J_TYPE = 3'd4
  } imm_sel_t;

  typedef struct packed {
    imm_sel_t sel;
    data_t    imm;
    data_t    base;
  } enc_req_t;

  // True when v[XLEN-1:lsb] are all copies of the sign bit.
  function automatic logic upper_same(input data_t v, input int lsb);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < XLEN; i++) begin
      if (i >= lsb && v[i] != v[XLEN-1]) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/imm_encoder_pack.sv
// Combinational field packer: scatters the immediate into the selected format's
// bit positions over the template word and flags values the format cannot hold.
module imm_encoder_pack
  import imm_encoder_pkg::*;
(
  input  enc_req_t req,
  output data_t    instr,
  output logic     err
);

  data_t mask;
  data_t field;
  data_t imm;

  assign imm = req.imm;

  always_comb begin
    mask  = '0;
    field = '0;
    err   = 1'b1;
    case (req.sel)
      IMM_I_TYPE: begin
        mask  = 32'hFFF0_0000;
        field = {imm[11:0], 20'b0};
        err   = !upper_same(imm, 11);
      end
      IMM_S_TYPE: begin
        mask  = 32'hFE00_0F80;
        field = {imm[11:5], 13'b0, imm[4:0], 7'b0};
        err   = !upper_same(imm, 11);
      end
      IMM_B_TYPE: begin
        mask  = 32'hFE00_0F80;
        field = {imm[12], imm[10:5], 13'b0, imm[4:1], imm[11], 7'b0};
        err   = !upper_same(imm, 12) || imm[0];
      end
      IMM_U_TYPE: begin
        mask  = 32'hFFFF_F000;
        field = {imm[31:12], 12'b0};
        err   = (imm[11:0] != 12'b0);
      end
      IMM_J_TYPE: begin
        mask  = 32'hFFFF_F000;
        field = {imm[20], imm[10:1], imm[11], imm[19:12], 12'b0};
        err   = !upper_same(imm, 20) || imm[0];
      end
      default: begin
        mask  = '0;
        field = '0;
        err   = 1'b1;
      end
    endcase
  end

  // Template bits survive wherever the format has no immediate field.
  for (genvar gi = 0; gi < XLEN; gi++) begin : g_merge
    assign instr[gi] = mask[gi] ? field[gi] : req.base[gi];
  end

endmodule

// File: rtl/imm_encoder.sv
// Two-stage valid/ready wrapper around the immediate packer with a saturating
// count of errored results handed to the consumer.
module imm_encoder
  import imm_encoder_pkg::*;
#(
  parameter int ERR_CNT_W = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  imm_sel_t             imm_sel_i,
  input  data_t                imm_i,
  input  data_t                base_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output data_t                instr_o,
  output logic                 err_o,
  output logic [ERR_CNT_W-1:0] err_cnt_o
);

  enc_req_t req;
  data_t    pack_instr;
  logic     pack_err;

  assign req = '{sel: imm_sel_i, imm: imm_i, base: base_i};

  imm_encoder_pack u_pack (
    .req   (req),
    .instr (pack_instr),
    .err   (pack_err)
  );

  logic                 s1_v_reg;
  data_t                s1_instr_reg;
  logic                 s1_err_reg;
  logic                 s2_v_reg;
  data_t                s2_instr_reg;
  logic                 s2_err_reg;
  logic [ERR_CNT_W-1:0] err_cnt_reg;

  logic s2_take;
  logic s1_adv;
  logic accept;
  logic deliver;

  // Ready depends on out_ready_i but never on in_valid_i.
  assign s2_take    = !s2_v_reg || out_ready_i;
  assign s1_adv     = s1_v_reg && s2_take;
  assign in_ready_o = !s1_v_reg || s2_take;
  assign accept     = in_valid_i && in_ready_o;
  assign deliver    = s2_v_reg && out_ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_v_reg     <= 1'b0;
      s1_instr_reg <= '0;
      s1_err_reg   <= 1'b0;
      s2_v_reg     <= 1'b0;
      s2_instr_reg <= '0;
      s2_err_reg   <= 1'b0;
      err_cnt_reg  <= '0;
    end else begin
      if (accept) begin
        s1_v_reg     <= 1'b1;
        s1_instr_reg <= pack_instr;
        s1_err_reg   <= pack_err;
      end else if (s1_adv) begin
        s1_v_reg <= 1'b0;
      end

      if (s2_take) begin
        s2_v_reg <= s1_v_reg;
      end
      if (s1_adv) begin
        s2_instr_reg <= s1_instr_reg;
        s2_err_reg   <= s1_err_reg;
      end

      if (deliver && s2_err_reg && (err_cnt_reg != '1)) begin
        err_cnt_reg <= err_cnt_reg + ERR_CNT_W'(1);
      end
    end
  end

  assign out_valid_o = s2_v_reg;
  assign instr_o     = s2_instr_reg;
  assign err_o       = s2_err_reg;
  assign err_cnt_o   = err_cnt_reg;

endmodule

// File: tb/tb_imm_encoder.sv
// Directed and randomised checks of the immediate encoder, decoding results
// with an independent ImmGen model.
module tb_imm_encoder;
  import imm_encoder_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic     rst;
  logic     in_valid;
  logic     out_ready;
  imm_sel_t sel;
  data_t    imm;
  data_t    base;

  logic        in_ready, out_valid, err;
  data_t       instr;
  logic [15:0] cnt;
  logic        in_ready4, out_valid4, err4;
  data_t       instr4;
  logic [3:0]  cnt4;

  int n_cmp = 0;
  int n_mis = 0;

  imm_encoder #(.ERR_CNT_W(16)) u_dut (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .imm_sel_i(sel), .imm_i(imm), .base_i(base), .out_valid_o(out_valid),
    .out_ready_i(out_ready), .instr_o(instr), .err_o(err), .err_cnt_o(cnt)
  );

  imm_encoder #(.ERR_CNT_W(4)) u_dut4 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready4),
    .imm_sel_i(sel), .imm_i(imm), .base_i(base), .out_valid_o(out_valid4),
    .out_ready_i(out_ready), .instr_o(instr4), .err_o(err4), .err_cnt_o(cnt4)
  );

  typedef struct {
    logic [2:0] s;
    data_t      i;
    data_t      b;
  } req_t;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Decode-side immediate generator.
  function automatic data_t immgen(input logic [2:0] s, input data_t ins);
    case (s)
      3'd0:    return {{20{ins[31]}}, ins[31:20]};
      3'd1:    return {{20{ins[31]}}, ins[31:25], ins[11:7]};
      3'd2:    return {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      3'd3:    return {ins[31:12], 12'b0};
      3'd4:    return {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      default: return ins;
    endcase
  endfunction

  function automatic logic model_err(input logic [2:0] s, input data_t i);
    int v;
    v = int'(i);
    case (s)
      3'd0, 3'd1: return !(v >= -2048 && v <= 2047);
      3'd2:       return !(v >= -4096 && v <= 4095 && i[0] == 1'b0);
      3'd3:       return (i[11:0] != 12'h000);
      3'd4:       return !(v >= -(1 << 20) && v < (1 << 20) && i[0] == 1'b0);
      default:    return 1'b1;
    endcase
  endfunction

  function automatic data_t rand_imm();
    data_t r;
    r = $urandom;
    case ($urandom_range(0, 4))
      0:       r = r;
      1:       r = {{20{r[11]}}, r[11:0]};
      2:       r = {{19{r[12]}}, r[12:0]};
      3:       r = {{11{r[20]}}, r[20:0]};
      default: r = {r[31:12], 12'b0};
    endcase
    if ($urandom_range(0, 1) == 1) r[0] = 1'b0;
    return r;
  endfunction

  task automatic check_out(input string tag, input data_t ins, input logic er, input req_t e);
    logic me;
    me = model_err(e.s, e.i);
    check_eq({tag, "_err"}, 32'(er), 32'(me));
    if (e.s > 3'd4) begin
      check_eq({tag, "_base"}, ins, e.b);
    end else begin
      check_eq({tag, "_opc"}, 32'(ins[6:0]), 32'(e.b[6:0]));
      if (!me) check_eq({tag, "_rt"}, immgen(e.s, ins), e.i);
    end
  endtask

  task automatic do_txn(input string tag, input imm_sel_t s, input data_t i, input data_t b,
                        input data_t exp_instr, input logic exp_err);
    sel = s; imm = i; base = b; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    check_eq({tag, "_rdy"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check_eq({tag, "_lat"}, 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check_eq({tag, "_vld"}, 32'(out_valid), 32'd1);
    check_eq({tag, "_instr"}, instr, exp_instr);
    check_eq({tag, "_err"}, 32'(err), 32'(exp_err));
    $display("txn %s: sel=%0d imm=%08h base=%08h -> instr=%08h err=%0d",
             tag, s, i, b, instr, err);
    @(posedge clk); #1;
  endtask

  initial begin
    data_t bp_exp[4];
    int    acc, got, first, last, cyc, seen, sent, errs;
    req_t  q[$];
    req_t  e;
    localparam int N = 300;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    sel = IMM_I_TYPE; imm = '0; base = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_eq("rst_vld", 32'(out_valid), 32'd0);
    check_eq("rst_instr", instr, 32'h0);
    check_eq("rst_err", 32'(err), 32'd0);
    check_eq("rst_cnt", 32'(cnt), 32'd0);
    check_eq("rst_rdy", 32'(in_ready), 32'd1);

    do_txn("i_neg1",  IMM_I_TYPE, 32'hFFFF_FFFF, 32'h0000_0013, 32'hFFF0_0013, 1'b0);
    do_txn("b_max",   IMM_B_TYPE, 32'h0000_0FFE, 32'h0000_0063, 32'h7E00_0FE3, 1'b0);
    do_txn("b_odd",   IMM_B_TYPE, 32'h0000_0003, 32'h0000_0063, 32'h0000_0163, 1'b1);
    check_eq("cnt_after_b_odd", 32'(cnt), 32'd1);
    do_txn("u_val",   IMM_U_TYPE, 32'h1234_5000, 32'h0000_0037, 32'h1234_5037, 1'b0);
    do_txn("j_m2",    IMM_J_TYPE, 32'hFFFF_FFFE, 32'h0000_006F, 32'hFFFF_F06F, 1'b0);
    do_txn("i_2048",  IMM_I_TYPE, 32'h0000_0800, 32'h0000_0013, 32'h8000_0013, 1'b1);
    check_eq("cnt_after_i_2048", 32'(cnt), 32'd2);
    do_txn("s_m4",    IMM_S_TYPE, 32'hFFFF_FFFC, 32'h0000_2023, 32'hFE00_2E23, 1'b0);
    do_txn("i_mask",  IMM_I_TYPE, 32'h0000_0000, 32'hFFFF_FFFF, 32'h000F_FFFF, 1'b0);
    do_txn("bad_sel", imm_sel_t'(3'd7), 32'h0000_0005, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1);
    check_eq("cnt_after_bad_sel", 32'(cnt), 32'd3);

    // Backpressure: four I-type requests against a stalled consumer.
    for (int k = 0; k < 4; k++) bp_exp[k] = (32'(k + 1) << 20) | 32'h13;
    out_ready = 1'b0; acc = 0;
    for (int c = 0; c < 4; c++) begin
      sel = IMM_I_TYPE; imm = 32'(acc + 1); base = 32'h13; in_valid = 1'b1;
      #1;
      if (in_ready) acc++;
      @(posedge clk); #1;
    end
    check_eq("bp_accepted", 32'(acc), 32'd2);
    check_eq("bp_rdy_low", 32'(in_ready), 32'd0);
    check_eq("bp_vld", 32'(out_valid), 32'd1);
    check_eq("bp_head", instr, bp_exp[0]);
    imm = 32'hFFFF_FFFF;
    repeat (2) @(posedge clk);
    #1;
    check_eq("bp_hold", instr, bp_exp[0]);
    check_eq("bp_hold_rdy", 32'(in_ready), 32'd0);

    out_ready = 1'b1; got = 0; first = -1; last = -1; cyc = 0;
    while (got < 4 && cyc < 20) begin
      if (acc < 4) begin
        in_valid = 1'b1; imm = 32'(acc + 1); base = 32'h13;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (out_valid) begin
        check_eq($sformatf("bp_out%0d", got), instr, bp_exp[got]);
        $display("txn bp_out%0d: instr=%08h", got, instr);
        if (first < 0) first = cyc;
        last = cyc;
        got++;
      end
      if (in_valid && in_ready) acc++;
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    check_eq("bp_delivered", 32'(got), 32'd4);
    check_eq("bp_rate", 32'(last - first), 32'd3);
    check_eq("bp_nodup", 32'(out_valid), 32'd0);

    // Reset with two errored items in flight.
    out_ready = 1'b0; sel = IMM_I_TYPE; imm = 32'h800; base = 32'h13; in_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1 in_valid = 1'b0;
    check_eq("rstf_inflight", 32'(out_valid), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_eq("rstf_vld", 32'(out_valid), 32'd0);
    check_eq("rstf_cnt", 32'(cnt), 32'd0);
    check_eq("rstf_rdy", 32'(in_ready), 32'd1);
    check_eq("rstf_instr", instr, 32'h0);
    out_ready = 1'b1; seen = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check_eq("rstf_nothing", 32'(seen), 32'd0);
    $display("txn reset_in_flight: cnt=%0d", cnt);

    // Random traffic with random backpressure, checked against the scoreboard.
    sent = 0; errs = 0; cyc = 0;
    while ((sent < N || q.size() != 0) && cyc < 5000) begin
      if (sent < N && $urandom_range(0, 3) != 0) begin
        in_valid = 1'b1;
        sel  = imm_sel_t'(3'($urandom_range(0, 7)));
        imm  = rand_imm();
        base = $urandom;
      end else begin
        in_valid = 1'b0;
      end
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      check_eq("rnd_rdy4", 32'(in_ready4), 32'(in_ready));
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check_eq("rnd_spurious", 32'(out_valid), 32'd0);
        end else begin
          e = q.pop_front();
          check_out("rnd", instr, err, e);
          check_eq("rnd4_vld", 32'(out_valid4), 32'd1);
          check_out("rnd4", instr4, err4, e);
          if (model_err(e.s, e.i)) errs++;
          $display("txn rnd sel=%0d imm=%08h base=%08h -> instr=%08h err=%0d",
                   e.s, e.i, e.b, instr, err);
        end
      end
      if (in_valid && in_ready) begin
        q.push_back('{s: 3'(sel), i: imm, b: base});
        sent++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    check_eq("rnd_done", 32'(q.size() == 0 && sent == N), 32'd1);
    check_eq("rnd_cnt16", 32'(cnt), 32'(errs));
    check_eq("rnd_cnt4_sat", 32'(cnt4), 32'((errs > 15) ? 15 : errs));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
